// File: rtl/nonce_uart_tx.sv
// nonce_uart_tx
//   Transmit side of the miner's host serial link. Golden nonces from the
//   hashing core are queued in a small FIFO and each one is sent as four
//   UART bytes on txd, low byte first (8N1). The bridge's tx_hold input
//   holds off the start of a new byte. A byte that has started always
//   completes.
//
//   Optional feature: define NONCE_TX_PARITY_EN to add an even-parity bit
//   after the data bits (8E1, 11-bit frames). Without it, frames are 8N1.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   nonce_valid  nonce present on `nonce` this cycle
//   nonce        32-bit golden nonce
//   nonce_ready  FIFO not full; push = nonce_valid & nonce_ready
//   tx_hold      asynchronous flow control (1 = do not start a new byte)
//   txd          serial line, idles high
//   busy         FIFO non-empty or frame in progress
//   overflow     1-clk pulse when a nonce is dropped (valid while not ready)
//   drop_cnt     saturating count of dropped nonces
module nonce_uart_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_ready,
  input  logic        tx_hold,
  output logic        txd,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef NONCE_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          hold_s1_q, hold_s1_d;
  logic          hold_s2_q, hold_s2_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          hold_s;
  logic          bit_end;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign push    = nonce_valid && !full;
  assign hold_s  = hold_s2_q;
  assign bit_end = (cnt_q == CNT_LAST);

  assign nonce_ready = !full;
  assign txd         = txd_q;
  assign busy        = !empty || (state_q != IDLE);
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

  // FIFO, synchroniser and drop accounting
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    hold_s1_d = tx_hold;
    hold_s2_d = hold_s1_q;
    if (push) begin
      mem_d[wr_ptr_q] = nonce;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overflow_d = nonce_valid && full;
    drop_cnt_d = drop_cnt_q;
    if (nonce_valid && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Transmit FSM. The word is popped on the IDLE->LOAD edge so the slot
  // frees one cycle after the first push. In STOP the counter parks at its
  // last value while held, so the stop-idle wait needs no extra state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (!hold_s) begin
          state_d = START;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[31:1]};
          par_d   = par_q ^ shift_q[0];
          if (bit_idx_q == 3'd7) begin
`ifdef NONCE_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef NONCE_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (!bit_end) begin
          cnt_d = cnt_q + CW'(1);
        end else if (byte_idx_q == 2'd3) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!hold_s) begin
          state_d    = START;
          cnt_d      = '0;
          par_d      = 1'b0;
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // txd is registered from the next state so it changes on the same edge
    // as the state and stays glitch-free.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef NONCE_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_s1_q  <= 1'b0;
      hold_s2_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_s1_q  <= hold_s1_d;
      hold_s2_q  <= hold_s2_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Directed testbench for nonce_uart_tx at DIV = 10 clocks per bit.
module tb_nonce_uart_tx;

  localparam int unsigned DIV = 10;
`ifdef NONCE_TX_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif

  logic        clk;
  logic        rst;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        nonce_ready;
  logic        tx_hold;
  logic        txd;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  nonce_uart_tx #(
    .CLK_HZ(1000000),
    .BAUD(100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nonce_valid(nonce_valid),
    .nonce(nonce),
    .nonce_ready(nonce_ready),
    .tx_hold(tx_hold),
    .txd(txd),
    .busy(busy),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    nonce_valid = 1'b1;
    nonce       = w;
    step();
    nonce_valid = 1'b0;
  endtask

  // Waits (bounded) for a start bit; n returns the number of cycles waited.
  task automatic wait_start(input string tag, output int unsigned n);
    n = 0;
    while (txd !== 1'b0 && n < 60 * DIV) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, {31'b0, txd}, 32'd0);
  endtask

  // Called just after the edge on which txd fell; returns mid-stop-bit.
  task automatic rx_from_start(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    b = '0;
    repeat (DIV / 2) step();
    check({tag, "_startbit"}, {31'b0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) step();
      b[i] = txd;
    end
    check({tag, "_data"}, {24'b0, b}, {24'b0, exp});
`ifdef NONCE_TX_PARITY_EN
    repeat (DIV) step();
    check({tag, "_parity"}, {31'b0, txd}, {31'b0, ^exp});
`endif
    repeat (DIV) step();
    check({tag, "_stop"}, {31'b0, txd}, 32'd1);
  endtask

  task automatic rx_byte(input string tag, input logic [7:0] exp);
    int unsigned n;
    wait_start(tag, n);
    rx_from_start(tag, exp);
  endtask

  logic [31:0] words [6];
  logic [7:0]  wb;
  int unsigned n;
  int unsigned bad;
  logic        exp_ovf;
  logic [7:0]  exp_drop;

  initial begin
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    words[2] = 32'h89ABCDEF;
    words[3] = 32'h0F1E2D3C;
    words[4] = 32'h55AA33CC;
    words[5] = 32'hBADBAD00;
    rst         = 1'b1;
    nonce_valid = 1'b0;
    nonce       = '0;
    tx_hold     = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_ready", {31'b0, nonce_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_drop", {24'b0, drop_cnt}, 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single word: latency, byte order, back-to-back bytes, busy fall
    push(32'h12345678);
    check("t1_busy_accept", {31'b0, busy}, 32'd1);
    check("t1_txd_n0", {31'b0, txd}, 32'd1);
    step();
    check("t1_txd_n1", {31'b0, txd}, 32'd1);
    step();
    check("t1_txd_n2", {31'b0, txd}, 32'd0);
    rx_from_start("t1_b0", 8'h78);
    wait_start("t1_b1", n);
    check("t1_gap1", n, DIV / 2);
    rx_from_start("t1_b1", 8'h56);
    wait_start("t1_b2", n);
    check("t1_gap2", n, DIV / 2);
    rx_from_start("t1_b2", 8'h34);
    wait_start("t1_b3", n);
    check("t1_gap3", n, DIV / 2);
    rx_from_start("t1_b3", 8'h12);
    repeat (DIV / 2 - 1) step();
    check("t1_busy_last", {31'b0, busy}, 32'd1);
    step();
    check("t1_busy_done", {31'b0, busy}, 32'd0);
    check("t1_txd_idle", {31'b0, txd}, 32'd1);

    // Six back-to-back pushes, held so the first word parks in LOAD:
    // pushes 0..4 fit (word 0 popped after the first edge), push 5 drops.
    tx_hold = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      nonce_valid = 1'b1;
      nonce       = words[i];
      check($sformatf("t2_ready%0d", i), {31'b0, nonce_ready}, (i < 5) ? 32'd1 : 32'd0);
      step();
      check($sformatf("t2_ovf%0d", i), {31'b0, overflow}, (i < 5) ? 32'd0 : 32'd1);
    end
    nonce_valid = 1'b0;
    check("t2_drop", {24'b0, drop_cnt}, 32'd1);
    step();
    check("t2_ovf_clear", {31'b0, overflow}, 32'd0);
    check("t2_ready_full", {31'b0, nonce_ready}, 32'd0);
    check("t2_drop_hold", {24'b0, drop_cnt}, 32'd1);
    tx_hold = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        wb = words[w][8*k +: 8];
        if (w == 1 && k == 0) begin
          // Word boundary: two idle-high clocks after the stop bit ends.
          repeat (DIV / 2) step();
          check("t2_gap_e0", {31'b0, txd}, 32'd1);
          step();
          check("t2_gap_e1", {31'b0, txd}, 32'd1);
          step();
          check("t2_gap_e2", {31'b0, txd}, 32'd0);
          rx_from_start("t2_w1b0", wb);
        end else begin
          rx_byte($sformatf("t2_w%0db%0d", w, k), wb);
        end
      end
    end
    repeat (DIV / 2) step();
    check("t2_busy_done", {31'b0, busy}, 32'd0);

    // Flow control during byte 1
    push(32'hA5A5A5A5);
    rx_byte("t3_b0", 8'hA5);
    wait_start("t3_b1", n);
    tx_hold = 1'b1;
    rx_from_start("t3_b1", 8'hA5);
    bad = 0;
    repeat (30) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("t3_held_high", bad, 32'd0);
    tx_hold = 1'b0;
    n = 0;
    while (txd === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("t3_release", {31'b0, (n >= 1 && n <= 3)}, 32'd1);
    rx_from_start("t3_b2", 8'hA5);
    rx_byte("t3_b3", 8'hA5);

    // Reset during DATA of byte 2 with a second word queued
    push(32'hCAFEBABE);
    push(32'h11111111);
    rx_byte("t4_b0", 8'hBE);
    rx_byte("t4_b1", 8'hBA);
    wait_start("t4_b2", n);
    repeat (DIV + 3) step();
    #2 rst = 1'b1;
    #1;
    check("t4_rst_txd", {31'b0, txd}, 32'd1);
    check("t4_rst_busy", {31'b0, busy}, 32'd0);
    check("t4_rst_ready", {31'b0, nonce_ready}, 32'd1);
    check("t4_rst_drop", {24'b0, drop_cnt}, 32'd0);
    step();
    rst = 1'b0;
    bad = 0;
    repeat (40 * DIV) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_quiet", bad, 32'd0);

    // Flood while held: 5 accepted, 295 dropped, counter saturates
    tx_hold = 1'b1;
    repeat (3) step();
    exp_drop = 8'd0;
    for (int i = 0; i < 300; i++) begin
      nonce_valid = 1'b1;
      nonce       = i;
      check($sformatf("t5_ready%0d", i), {31'b0, nonce_ready}, (i < 5) ? 32'd1 : 32'd0);
      step();
      exp_ovf = (i >= 5);
      if (exp_ovf && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      check($sformatf("t5_ovf%0d", i), {31'b0, overflow}, {31'b0, exp_ovf});
      check($sformatf("t5_drop%0d", i), {24'b0, drop_cnt}, {24'b0, exp_drop});
    end
    nonce_valid = 1'b0;
    step();
    check("t5_ovf_end", {31'b0, overflow}, 32'd0);
    check("t5_drop_sat", {24'b0, drop_cnt}, 32'd255);

    rst = 1'b1;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
